// File: rtl/axis_counter_v2_pkg.sv
// axis_counter_v2_pkg: shared types and LFSR tap table for the axis_counter_v2
// test-pattern generator. The LFSR taps are only consumed when the design is
// built with AXIS_COUNTER_LFSR_EN defined.
package axis_counter_v2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Galois (right-shift) feedback masks for maximal-length LFSRs.
  // Widths outside the table fall back to a single top tap (not maximal).
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 64'h0000_000C;
      5:       lfsr_taps = 64'h0000_0014;
      6:       lfsr_taps = 64'h0000_0030;
      7:       lfsr_taps = 64'h0000_0060;
      8:       lfsr_taps = 64'h0000_00B8;
      9:       lfsr_taps = 64'h0000_0110;
      10:      lfsr_taps = 64'h0000_0240;
      12:      lfsr_taps = 64'h0000_0E08;
      15:      lfsr_taps = 64'h0000_6000;
      16:      lfsr_taps = 64'h0000_B400;
      24:      lfsr_taps = 64'h00E1_0000;
      32:      lfsr_taps = 64'h8020_0003;
      default: lfsr_taps = 64'h1 << (width - 1);
    endcase
  endfunction

endpackage

// File: rtl/axis_counter_v2_pat.sv
// axis_counter_v2_pat: next-value unit for the pattern generator.
// Computes the following beat value from the current one (up / down / LFSR)
// and the effective run seed. LFSR mode exists only when AXIS_COUNTER_LFSR_EN
// is defined; otherwise mode 2 (and reserved mode 3) count up.
module axis_counter_v2_pat
  import axis_counter_v2_pkg::*;
#(
  parameter int BDATA = 16
) (
  input  mode_t            i_mode,
  input  logic [BDATA-1:0] i_cur,
  input  logic [BDATA-1:0] i_step,
  input  logic [BDATA-1:0] i_seed,
  output logic [BDATA-1:0] o_next,
  output logic [BDATA-1:0] o_seed
);

`ifdef AXIS_COUNTER_LFSR_EN
  localparam logic [63:0]      TAPS64 = lfsr_taps(BDATA);
  localparam logic [BDATA-1:0] TAPS   = TAPS64[BDATA-1:0];
`endif

  // Next beat value; arithmetic wraps modulo 2^BDATA.
  always_comb begin
    o_next = i_cur + i_step;
    case (i_mode)
      MODE_DOWN: o_next = i_cur - i_step;
`ifdef AXIS_COUNTER_LFSR_EN
      MODE_LFSR: o_next = (i_cur >> 1) ^ (i_cur[0] ? TAPS : '0);
`endif
      default:   o_next = i_cur + i_step;
    endcase
  end

  // Run seed; an all-zero LFSR state would lock up, so it is replaced by 1.
  always_comb begin
    o_seed = i_seed;
`ifdef AXIS_COUNTER_LFSR_EN
    if (i_mode == MODE_LFSR && i_seed == '0) o_seed = {{(BDATA-1){1'b0}}, 1'b1};
`endif
  end

endmodule

// File: rtl/axis_counter_v2.sv
// axis_counter_v2: AXI4-Stream framed test-pattern generator.
// Framing/FSM lives here; value sequencing is in axis_counter_v2_pat.
// Optional feature macro: AXIS_COUNTER_LFSR_EN (mode 2 = Galois LFSR).
module axis_counter_v2
  import axis_counter_v2_pkg::*;
#(
  parameter int BDATA = 16,
  parameter int BUSER = 8,
  parameter int BLEN  = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [BLEN-1:0]  cfg_ndata,
  input  logic [BLEN-1:0]  cfg_wait,
  input  logic [BLEN-1:0]  cfg_nframes,
  input  logic [BDATA-1:0] cfg_step,
  input  logic [BDATA-1:0] cfg_seed,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [BDATA-1:0] m_axis_tdata,
  output logic [BUSER-1:0] m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [BLEN-1:0]  frames_done
);

  state_t           r_state, w_next_state;
  mode_t            r_mode;
  mode_t            w_pat_mode;
  logic [BDATA-1:0] r_step;
  logic [BLEN-1:0]  r_ndata_m1;
  logic [BLEN-1:0]  r_wait;
  logic [BLEN-1:0]  r_nframes;
  logic [BDATA-1:0] r_data;
  logic [BUSER-1:0] r_user;
  logic [BLEN-1:0]  r_beat;
  logic [BLEN-1:0]  r_gap_cnt;
  logic             r_stop;
  logic [BLEN-1:0]  r_frames_done;
  logic [BDATA-1:0] w_next_data;
  logic [BDATA-1:0] w_seed;
  logic             w_fire;
  logic             w_last;
  logic             w_frame_end;
  logic             w_nframes_hit;
  logic             w_stop_gap;

  function automatic logic [BLEN-1:0] sat_inc(input logic [BLEN-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // While IDLE the live mode decides the seed; during a run the latched mode drives stepping.
  assign w_pat_mode = (r_state == IDLE) ? mode_t'(cfg_mode) : r_mode;

  axis_counter_v2_pat #(
    .BDATA (BDATA)
  ) u_pat (
    .i_mode (w_pat_mode),
    .i_cur  (r_data),
    .i_step (r_step),
    .i_seed (cfg_seed),
    .o_next (w_next_data),
    .o_seed (w_seed)
  );

  assign w_fire        = m_axis_tvalid & m_axis_tready;
  assign w_last        = (r_state == RUN) && (r_beat == r_ndata_m1);
  assign w_frame_end   = w_fire & w_last;
  assign w_nframes_hit = (r_nframes != '0) && (r_frames_done == r_nframes - 1'b1);
  assign w_stop_gap    = r_stop | ~cfg_start;

  assign m_axis_tdata = r_data;
  assign m_axis_tuser = r_user;
  assign frames_done  = r_frames_done;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and stream control outputs.
  always_comb begin
    w_next_state  = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) w_next_state = RUN;
      end
      RUN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = w_last;
        if (w_frame_end) begin
          if (w_nframes_hit || !cfg_start) w_next_state = IDLE;
          else if (r_wait != '0)           w_next_state = GAP;
          else                             w_next_state = RUN;
        end
      end
      GAP: begin
        // r_gap_cnt counts down from cfg_wait; 1 marks the final idle cycle.
        if (r_gap_cnt == 1) w_next_state = w_stop_gap ? IDLE : RUN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Configuration snapshot, taken only on the IDLE->RUN transition.
  always_ff @(posedge aclk) begin
    if (r_state == IDLE && cfg_start) begin
      r_mode     <= mode_t'(cfg_mode);
      r_step     <= cfg_step;
      r_ndata_m1 <= (cfg_ndata == '0) ? '0 : cfg_ndata - 1'b1;
      r_wait     <= cfg_wait;
      r_nframes  <= cfg_nframes;
    end
  end

  // Beat value, frame index, beat/gap counters and frame tally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_data        <= '0;
      r_user        <= '0;
      r_beat        <= '0;
      r_gap_cnt     <= '0;
      r_stop        <= 1'b0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_data        <= w_seed;
            r_user        <= '0;
            r_beat        <= '0;
            r_stop        <= 1'b0;
            r_frames_done <= '0;
          end
        end
        RUN: begin
          if (w_fire) begin
            r_data <= w_next_data;
            if (w_last) begin
              r_beat        <= '0;
              r_user        <= r_user + 1'b1;
              r_frames_done <= sat_inc(r_frames_done);
              r_gap_cnt     <= r_wait;
              r_stop        <= 1'b0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          if (!cfg_start) r_stop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_counter_v2.sv
// tb_axis_counter_v2: directed self-checking bench for axis_counter_v2.
// Build with AXIS_COUNTER_LFSR_EN defined to exercise the LFSR mode instead of
// the mode-2-equals-up behaviour.
module tb_axis_counter_v2;

  localparam int BDATA = 16;
  localparam int BUSER = 8;
  localparam int BLEN  = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             cfg_start;
  logic [1:0]       cfg_mode;
  logic [BLEN-1:0]  cfg_ndata;
  logic [BLEN-1:0]  cfg_wait;
  logic [BLEN-1:0]  cfg_nframes;
  logic [BDATA-1:0] cfg_step;
  logic [BDATA-1:0] cfg_seed;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [BDATA-1:0] m_axis_tdata;
  logic [BUSER-1:0] m_axis_tuser;
  logic             m_axis_tlast;
  logic             busy;
  logic [BLEN-1:0]  frames_done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [BDATA-1:0] exp_data [64];
  logic [BUSER-1:0] exp_user [64];
  logic             exp_last [64];
  int               exp_idle [64];

  localparam logic [7:0] READY_PAT = 8'b1011_0010;

  always #5 aclk = ~aclk;

  axis_counter_v2 #(
    .BDATA (BDATA),
    .BUSER (BUSER),
    .BLEN  (BLEN)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_mode      (cfg_mode),
    .cfg_ndata     (cfg_ndata),
    .cfg_wait      (cfg_wait),
    .cfg_nframes   (cfg_nframes),
    .cfg_step      (cfg_step),
    .cfg_seed      (cfg_seed),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frames_done   (frames_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input int ndata, input int wt,
                         input int nfr, input int step, input int seed);
    cfg_mode    = mode;
    cfg_ndata   = BLEN'(ndata);
    cfg_wait    = BLEN'(wt);
    cfg_nframes = BLEN'(nfr);
    cfg_step    = BDATA'(step);
    cfg_seed    = BDATA'(seed);
  endtask

  // Expected beats of a linear run: value continues across frames.
  task automatic fill(input int n, input int seed, input int step, input bit down,
                      input int ndata, input int wt);
    logic [BDATA-1:0] v;
    v = BDATA'(seed);
    for (int k = 0; k < n; k++) begin
      exp_data[k] = v;
      exp_user[k] = BUSER'(k / ndata);
      exp_last[k] = ((k % ndata) == ndata - 1);
      exp_idle[k] = (k != 0 && (k % ndata) == 0) ? wt : 0;
      v = down ? v - BDATA'(step) : v + BDATA'(step);
    end
  endtask

  // Consume beats first..first+n-1, checking every valid cycle (stalled ones too).
  task automatic run_beats(input int first, input int n, input bit stall);
    int k;
    int idle;
    int cyc;
    bit fresh;
    k = first; idle = 0; cyc = 0; fresh = 1'b1;
    while (k < first + n && cyc < 2000) begin
      m_axis_tready = stall ? READY_PAT[cyc % 8] : 1'b1;
      if (m_axis_tvalid) begin
        if (fresh) begin
          chk($sformatf("idle[%0d]", k), idle, exp_idle[k]);
          fresh = 1'b0;
        end
        chk($sformatf("tdata[%0d]", k), m_axis_tdata, exp_data[k]);
        chk($sformatf("tuser[%0d]", k), m_axis_tuser, exp_user[k]);
        chk($sformatf("tlast[%0d]", k), m_axis_tlast, exp_last[k]);
        if (m_axis_tready) begin
          k++; idle = 0; fresh = 1'b1;
        end
      end else begin
        idle++;
      end
      tick();
      cyc++;
    end
    if (k < first + n) chk("beat_timeout", k, first + n);
    m_axis_tready = 1'b1;
  endtask

  initial begin
    aresetn       = 1'b0;
    cfg_start     = 1'b0;
    m_axis_tready = 1'b1;
    set_cfg(2'd0, 1, 0, 0, 1, 0);
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_done, 0);

    // 1: two back-to-back frames of 4, stops on nframes
    set_cfg(2'd0, 4, 0, 2, 1, 0);
    fill(8, 0, 1, 0, 4, 0);
    cfg_start = 1'b1;
    tick();
    chk("t1_latency_tvalid", m_axis_tvalid, 1);
    run_beats(0, 8, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_tvalid_end", m_axis_tvalid, 0);
    chk("t1_frames_done", frames_done, 2);
    cfg_start = 1'b0;
    tick();
    chk("t1_frames_hold", frames_done, 2);
    chk("t1_busy_idle", busy, 0);

    // 2: inter-frame gap of 3, reserved mode counts up
    set_cfg(2'd3, 2, 3, 3, 1, 0);
    fill(6, 0, 1, 0, 2, 3);
    cfg_start = 1'b1;
    tick();
    run_beats(0, 6, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_frames_done", frames_done, 3);
    cfg_start = 1'b0;
    tick();

    // 3: down count with wrap under tready stalls
    set_cfg(2'd1, 3, 0, 1, 3, 2);
    exp_data[0] = 16'h0002; exp_data[1] = 16'hFFFF; exp_data[2] = 16'hFFFC;
    for (int k = 0; k < 3; k++) begin
      exp_user[k] = '0;
      exp_last[k] = (k == 2);
      exp_idle[k] = 0;
    end
    cfg_start = 1'b1;
    tick();
    run_beats(0, 3, 1);
    chk("t3_busy_end", busy, 0);
    chk("t3_frames_done", frames_done, 1);
    cfg_start = 1'b0;
    tick();

    // 4: continuous run, stop requested mid-frame finishes the frame
    set_cfg(2'd0, 10, 0, 0, 1, 100);
    fill(50, 100, 1, 0, 10, 0);
    cfg_start = 1'b1;
    tick();
    cfg_step = 16'd7;
    run_beats(0, 44, 0);
    cfg_start = 1'b0;
    run_beats(44, 6, 0);
    chk("t4_busy_end", busy, 0);
    chk("t4_tvalid_end", m_axis_tvalid, 0);
    chk("t4_frames_done", frames_done, 5);
    tick();

    // 5: reset during beat 2 of the second frame
    set_cfg(2'd0, 4, 0, 0, 1, 16'h55);
    fill(8, 16'h55, 1, 0, 4, 0);
    cfg_start = 1'b1;
    tick();
    run_beats(0, 6, 0);
    chk("t5_pre_frames", frames_done, 1);
    chk("t5_pre_tdata", m_axis_tdata, 16'h5B);
    aresetn   = 1'b0;
    cfg_start = 1'b0;
    tick();
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_tuser", m_axis_tuser, 0);
    chk("t5_busy", busy, 0);
    chk("t5_frames", frames_done, 0);
    aresetn = 1'b1;
    tick();

`ifdef AXIS_COUNTER_LFSR_EN
    // 6: LFSR, zero seed becomes 1, full period 2^16-1
    begin
      int cnt;
      set_cfg(2'd2, 1, 0, 0, 5, 0);
      cfg_start = 1'b1;
      tick();
      chk("t6_lfsr_first", m_axis_tdata, 1);
      cnt = 0;
      while (cnt < 70000) begin
        tick();
        cnt++;
        if (m_axis_tdata == 16'd1) break;
      end
      chk("t6_lfsr_period", cnt, 65535);
      cfg_start = 1'b0;
      repeat (3) tick();
      chk("t6_busy_end", busy, 0);
    end
`else
    // 6: without LFSR support mode 2 counts up
    set_cfg(2'd2, 3, 0, 1, 2, 10);
    fill(3, 10, 2, 0, 3, 0);
    cfg_start = 1'b1;
    tick();
    run_beats(0, 3, 0);
    chk("t6_busy_end", busy, 0);
    cfg_start = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
